// File: rtl/riscv_multicycle_control.sv
// Multicycle RISC-V control unit: IF/ID/EX/MEM/WB sequencing for R-type,
// I-ALU, lw, sw and beq, with a data-memory wait timeout into a sticky ERR.
// All control outputs decode combinationally from the state register and
// the (held-stable) instruction word.
module riscv_multicycle_control #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        Zero,
  input  logic        dReady,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        loadPC,
  output logic [3:0]  ALUCtrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  state,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  localparam bit         TO_EN  = (TIMEOUT_CYCLES > 0);

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign funct7      = instruction[31:25];
  assign unused_bits = ^{instruction[24:15], instruction[11:7]};

  logic       f3_ok;
  logic [3:0] f3_alu;
  logic       legal, is_alu, is_ld, is_st, is_br, alusrc_dec;
  logic [3:0] alu_dec;

  // funct3 operation table shared by R-type and I-ALU
  always_comb begin
    f3_ok  = 1'b1;
    f3_alu = ALU_ADD;
    case (funct3)
      3'b000:  f3_alu = ALU_ADD;
      3'b111:  f3_alu = ALU_AND;
      3'b110:  f3_alu = ALU_OR;
      3'b100:  f3_alu = ALU_XOR;
      3'b010:  f3_alu = ALU_SLT;
      default: f3_ok  = 1'b0;
    endcase
  end

  // instruction class, legality, ALU operation and operand select
  always_comb begin
    legal      = 1'b0;
    is_alu     = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_br      = 1'b0;
    alusrc_dec = 1'b0;
    alu_dec    = ALU_ADD;
    case (opcode)
      OP_R: begin
        is_alu  = 1'b1;
        // only funct7=0000000, plus 0100000 for sub, are defined
        legal   = f3_ok && ((funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && funct3 == 3'b000));
        alu_dec = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : f3_alu;
      end
      OP_I: begin
        is_alu     = 1'b1;
        legal      = f3_ok;
        alu_dec    = f3_alu;
        alusrc_dec = 1'b1;
      end
      OP_LD: begin
        is_ld      = 1'b1;
        legal      = (funct3 == 3'b010);
        alusrc_dec = 1'b1;
      end
      OP_ST: begin
        is_st      = 1'b1;
        legal      = (funct3 == 3'b010);
        alusrc_dec = 1'b1;
      end
      OP_BR: begin
        is_br   = 1'b1;
        legal   = (funct3 == 3'b000);
        alu_dec = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
  end

  // next-state and memory wait counter
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: state_d = legal ? S_EX : S_ERR;
      S_EX: begin
        wcnt_d = '0;
        if (is_alu)              state_d = S_WB;
        else if (is_ld || is_st) state_d = S_MEM;
        else if (is_br)          state_d = S_IF;
        else                     state_d = S_ERR;
      end
      S_MEM: begin
        if (dReady) begin
          wcnt_d  = '0;
          state_d = is_ld ? S_WB : S_IF;
        end else begin
          if (!TO_EN || wcnt_q == TO_LIM) wcnt_d = wcnt_q;
          else                            wcnt_d = wcnt_q + 8'd1;
          if (TO_EN && wcnt_d == TO_LIM)  state_d = S_ERR;
        end
      end
      S_WB:    state_d = S_IF;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // control outputs decoded from state and instruction
  always_comb begin
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    loadPC   = 1'b0;
    ALUCtrl  = 4'b0000;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    state    = state_q;
    error    = (state_q == S_ERR);
    case (state_q)
      S_EX: begin
        ALUCtrl = alu_dec;
        ALUSrc  = alusrc_dec;
        if (is_br) begin
          loadPC = 1'b1;
          PCSrc  = Zero;
        end
      end
      S_MEM: begin
        ALUCtrl  = alu_dec;
        ALUSrc   = alusrc_dec;
        MemRead  = is_ld;
        MemWrite = is_st;
        loadPC   = is_st & dReady;
      end
      S_WB: begin
        ALUCtrl  = alu_dec;
        ALUSrc   = alusrc_dec;
        RegWrite = 1'b1;
        MemtoReg = is_ld;
        loadPC   = 1'b1;
      end
      default: ;
    endcase
  end

  // state and wait counter registers, asynchronously cleared by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Bench for riscv_multicycle_control: directed scenarios plus random
// instructions, checked every cycle against an instruction-level model.
module tb_riscv_multicycle_control;

  localparam int TO = 15;

  localparam int C_R   = 0;
  localparam int C_I   = 1;
  localparam int C_L   = 2;
  localparam int C_S   = 3;
  localparam int C_B   = 4;
  localparam int C_ILL = 5;

  // funct3 -> ALU op, and which funct3 values are defined
  localparam logic [3:0] F3_ALU [8] = '{4'b0010, 4'b0000, 4'b0111, 4'b0000,
                                        4'b1101, 4'b0000, 4'b0001, 4'b0000};
  localparam logic [7:0] F3_OK = 8'b11010101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic        Zero = 1'b0;
  logic        dReady = 1'b0;
  logic        PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC, MemRead, MemWrite, error;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;

  riscv_multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .Zero(Zero), .dReady(dReady),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .loadPC(loadPC), .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
    .state(state), .error(error)
  );

  always #5 clk = ~clk;

  logic [2:0]  e_state;
  logic        e_error, e_pcsrc, e_alusrc, e_regw, e_m2r, e_lpc, e_mrd, e_mwr;
  logic [3:0]  e_alu;
  bit          chk_en = 1'b0;
  int          cyc_k = 0;
  int          lit_lat = 0;
  int          lit_err = 0;
  bit          lit_alu_en = 1'b0;
  logic [3:0]  lit_alu = 4'b0000;
  int          vecs = 0;
  int          fails = 0;
  logic [14:0] got_v, exp_v;

  // compare process: every negedge while checking is enabled
  always @(negedge clk) begin
    if (chk_en) begin
      got_v = {state, error, PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC, ALUCtrl, MemRead, MemWrite};
      exp_v = {e_state, e_error, e_pcsrc, e_alusrc, e_regw, e_m2r, e_lpc, e_alu, e_mrd, e_mwr};
      vecs++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL outputs k=%0d instr=%h got=%b want=%b (state,err,pcsrc,alusrc,regw,m2r,lpc,alu,mrd,mwr)",
                 cyc_k, instruction, got_v, exp_v);
      end
      if (lit_lat != 0 && loadPC === 1'b1) begin
        vecs++;
        if (cyc_k != lit_lat) begin
          fails++;
          $display("FAIL latency instr=%h loadPC at cycle %0d, want cycle %0d", instruction, cyc_k, lit_lat);
        end
      end
      if (lit_alu_en && state == 3'd2) begin
        vecs++;
        if (ALUCtrl !== lit_alu) begin
          fails++;
          $display("FAIL ex_aluctrl instr=%h got=%b want=%b", instruction, ALUCtrl, lit_alu);
        end
      end
      if (lit_err != 0) begin
        vecs++;
        if (error !== 1'(cyc_k >= lit_err)) begin
          fails++;
          $display("FAIL err_timing instr=%h k=%0d error=%b, error expected from cycle %0d",
                   instruction, cyc_k, error, lit_err);
        end
      end
    end
  end

  function automatic void model_decode(input logic [31:0] ins, output int cls, output logic [3:0] alu);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    cls = C_ILL;
    alu = 4'b0010;
    if (op == 7'b0110011) begin
      if (F3_OK[f3] && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000))) cls = C_R;
      alu = (f3 == 3'b000 && f7 == 7'h20) ? 4'b0110 : F3_ALU[f3];
    end else if (op == 7'b0010011) begin
      if (F3_OK[f3]) cls = C_I;
      alu = F3_ALU[f3];
    end else if (op == 7'b0000011) begin
      if (f3 == 3'b010) cls = C_L;
    end else if (op == 7'b0100011) begin
      if (f3 == 3'b010) cls = C_S;
    end else if (op == 7'b1100011) begin
      if (f3 == 3'b000) cls = C_B;
      alu = 4'b0110;
    end
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 5);
    case (sel)
      0: w[6:0] = 7'b0110011;
      1: w[6:0] = 7'b0010011;
      2: w[6:0] = 7'b0000011;
      3: w[6:0] = 7'b0100011;
      4: w[6:0] = 7'b1100011;
      default: ;
    endcase
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) begin
      if (sel == 2 || sel == 3) w[14:12] = 3'b010;
      if (sel == 4) w[14:12] = 3'b000;
    end
    return w;
  endfunction

  task automatic set_exp(input logic [2:0] s, input logic er, input logic pcs, input logic als,
                         input logic rw, input logic m2r, input logic lpc, input logic [3:0] alu,
                         input logic mrd, input logic mwr);
    e_state = s;  e_error = er; e_pcsrc = pcs; e_alusrc = als; e_regw = rw;
    e_m2r = m2r;  e_lpc = lpc;  e_alu = alu;   e_mrd = mrd;    e_mwr = mwr;
  endtask

  task automatic step(input int k);
    cyc_k = k;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_lit();
    lit_lat    = 0;
    lit_err    = 0;
    lit_alu_en = 1'b0;
  endtask

  // assert rst between edges, hold it two cycles, release between edges
  task automatic do_reset();
    clr_lit();
    rst = 1'b1;
    set_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(0);
    step(0);
    rst = 1'b0;
  endtask

  task automatic err_cycles(input int k0);
    for (int i = 0; i < 3; i++) begin
      dReady = 1'($urandom % 2);
      Zero   = 1'($urandom % 2);
      set_exp(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
      step(k0 + i);
    end
  endtask

  // waits: -1 random, else dReady-low MEM cycles; zmode: -1 random, else Zero;
  // rst_at: -1 none, else reset asserted in that MEM cycle
  task automatic run_instr(input logic [31:0] ins, input int waits, input int zmode, input int rst_at);
    int cls, k, z;
    logic [3:0] alu;
    logic src, ld, st, br, dr, zf;
    model_decode(ins, cls, alu);
    src = (cls == C_I || cls == C_L || cls == C_S);
    ld  = (cls == C_L);
    st  = (cls == C_S);
    br  = (cls == C_B);
    instruction = ins;
    Zero   = 1'($urandom % 2);
    dReady = 1'($urandom % 2);
    set_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(1);
    dReady = 1'($urandom % 2);
    set_exp(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    step(2);
    if (cls == C_ILL) begin
      err_cycles(3);
      do_reset();
      return;
    end
    zf = (zmode < 0) ? 1'($urandom % 2) : 1'(zmode);
    Zero = zf;
    set_exp(3'd2, 1'b0, br & zf, src, 1'b0, 1'b0, br, alu, 1'b0, 1'b0);
    step(3);
    if (br) return;
    k = 4;
    if (ld || st) begin
      z = 0;
      forever begin
        if (rst_at >= 0 && z == rst_at) begin
          do_reset();
          return;
        end
        dr = (waits >= 0) ? 1'(z == waits) : 1'($urandom % 3 == 0);
        dReady = dr;
        Zero   = 1'($urandom % 2);
        set_exp(3'd3, 1'b0, 1'b0, src, 1'b0, 1'b0, st & dr, alu, ld, st);
        step(k);
        k++;
        if (dr) break;
        z++;
        if (TO > 0 && z == TO) begin
          err_cycles(k);
          do_reset();
          return;
        end
      end
      if (st) return;
    end
    dReady = 1'($urandom % 2);
    set_exp(3'd4, 1'b0, 1'b0, src, 1'b1, ld, 1'b1, alu, 1'b0, 1'b0);
    step(k);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // add x3,x1,x2
    lit_lat = 4; lit_alu_en = 1'b1; lit_alu = 4'b0010;
    run_instr(32'h002081B3, -1, -1, -1);
    clr_lit();
    // lw x5,8(x2) with two wait cycles
    lit_lat = 7; lit_alu_en = 1'b1; lit_alu = 4'b0010;
    run_instr(32'h00812283, 2, -1, -1);
    clr_lit();
    // beq taken and not taken
    lit_lat = 3; lit_alu_en = 1'b1; lit_alu = 4'b0110;
    run_instr(32'h00208463, -1, 1, -1);
    run_instr(32'h00208463, -1, 0, -1);
    clr_lit();
    // sw with one wait cycle
    lit_lat = 5; lit_alu_en = 1'b1; lit_alu = 4'b0010;
    run_instr(32'h0020A223, 1, -1, -1);
    clr_lit();
    // sw with dReady never arriving: 15 MEM cycles then ERR at cycle 19
    lit_err = 3 + TO + 1;
    run_instr(32'h0020A223, 1000, -1, -1);
    // illegal opcode: ERR right after ID
    lit_err = 3;
    run_instr(32'h0000007F, -1, -1, -1);
    // reset in the middle of a load's MEM wait, and of a store's
    run_instr(32'h00812283, 5, -1, 1);
    run_instr(32'h0020A223, 5, -1, 0);
    // xor / sub / slti directed
    run_instr(32'h0020C1B3, -1, -1, -1);
    run_instr(32'h402081B3, -1, -1, -1);
    run_instr(32'h0050A193, -1, -1, -1);

    for (int n = 0; n < 400; n++) begin
      run_instr(gen_instr(), -1, -1, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 2) : -1);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_control.md
RISCV_MULTICYCLE_CONTROL -- requirements
Module: riscv_multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, giving the maximum MEM-state wait cycles with dReady low; 0 disables the timeout; legal range 0-255.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- instruction  in  32  current instruction; held stable by the environment from IF through the final state of that instruction.
- Zero  in  1  ALU zero flag from the datapath.
- dReady  in  1  data memory done; dReadData is held valid until the next request.
- PCSrc  out  1  branch-target select.
- ALUSrc  out  1  immediate operand select.
- RegWrite  out  1  register file write enable.
- MemtoReg  out  1  write-back from memory select.
- loadPC  out  1  PC update enable.
- ALUCtrl  out  4  ALU operation.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- state  out  3  current state.
- error  out  1  sticky fault flag.

Function
REQ-003 SHALL implement a registered FSM with these states and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7.
REQ-004 SHALL decode every output combinationally from the registered state and instruction; no output SHALL be registered separately.
REQ-005 SHALL sequence transitions as follows:
- IF -> ID, unconditionally.
- ID -> EX for a legal instruction; ID -> ERR for an illegal one.
REQ-006 SHALL leave EX as follows:
- R-type (0110011) and I-ALU (0010011): EX -> WB.
- Load (0000011) and store (0100011): EX -> MEM.
- Branch (1100011): EX -> IF.
REQ-007 SHALL leave MEM as follows:
- Stay in MEM while dReady=0.
- On dReady=1: load -> WB, store -> IF.
- If TIMEOUT_CYCLES>0 and TIMEOUT_CYCLES consecutive MEM cycles see dReady=0: -> ERR.
REQ-008 SHALL transition WB -> IF unconditionally.
REQ-009 SHALL make ERR absorbing until reset, with error=1 and every other control output 0 while in ERR.
REQ-010 SHALL decode ALUCtrl as AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, XOR=1101.
REQ-011 SHALL map R-type funct3 as follows; any other funct3/funct7 combination is illegal:
- 000: ADD if funct7[5]=0, SUB if funct7[5]=1.
- 111: AND.
- 110: OR.
- 100: XOR.
- 010: SLT.
REQ-012 SHALL map I-ALU with the same funct3 table, with 000 always ADD and funct7 ignored.
REQ-013 SHALL accept loads and stores only with funct3=010 (decoding to ADD) and branches only with funct3=000 (beq, decoding to SUB); any other opcode or funct3 is illegal.
REQ-014 SHALL drive ALUCtrl and ALUSrc with the decoded value in EX, MEM and WB, and with 0 in IF, ID and ERR.
REQ-015 SHALL set ALUSrc=1 for I-ALU, load and store instructions.
REQ-016 SHALL assert MemRead (load) or MemWrite (store) in every MEM cycle, and never both.
REQ-017 SHALL assert RegWrite only in WB, with MemtoReg=1 in WB only for loads.
REQ-018 SHALL assert loadPC for exactly one cycle per instruction, in its final state:
- WB for R-type, I-ALU and load.
- MEM with dReady=1 for store.
- EX for branch.
REQ-019 SHALL assert PCSrc only in branch EX when Zero=1.
REQ-020 SHALL use an 8-bit wait counter that clears on MEM entry and on every cycle with dReady=1, and saturates at TIMEOUT_CYCLES.
REQ-021 SHALL give these instruction latencies:
- R-type and I-ALU: 4 cycles.
- Branch: 3 cycles.
- Store: 4+w cycles.
- Load: 5+w cycles.
- w = number of MEM cycles with dReady=0.

Reset
REQ-022 SHALL, while rst=1, immediately force state=IF, the wait counter to 0 and error=0, and force every control output to 0 regardless of clk.
REQ-023 SHALL abandon an in-progress instruction when rst asserts mid-instruction, with no RegWrite or loadPC issued for it.
REQ-024 SHALL enter ID on the first rising clk edge after rst deasserts.

Verification
REQ-025 SHALL cover these scenarios:
- instruction=0x002081B3 (add x3,x1,x2) -> states 0,1,2,4; ALUCtrl=0010 in cycles 3-4; RegWrite=1 and loadPC=1 only in cycle 4; MemtoReg=0.
- instruction=0x00812283 (lw x5,8(x2)), dReady low 2 cycles -> MEM cycles 4-6 with MemRead=1; WB in cycle 7 with RegWrite=1, MemtoReg=1, loadPC=1; ALUSrc=1 and ALUCtrl=0010 in cycles 3-7.
- instruction=0x00208463 (beq), Zero=1 -> cycle 3 has PCSrc=1, loadPC=1, ALUCtrl=0110; repeat with Zero=0 -> PCSrc=0, loadPC=1.
- instruction=0x0020A223 (sw), dReady held 0, TIMEOUT_CYCLES=15 -> MemWrite=1 for 15 cycles, then state=7, error=1, all controls 0, held until rst.
- instruction=0x0000007F -> ERR entered directly after ID, error=1; then rst pulse -> state=0, error=0 asynchronously.
- rst asserted mid-MEM of a load, between clock edges -> MemRead, RegWrite and loadPC drop to 0 immediately; state=0.
